ras: RTL

RAS -- requirements
Module: ras

---
 rtl/ras.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ras.sv
// Return address stack: a circular array of low-PC return targets with a
// next-free pointer and a saturating valid-entry count. The top of stack is
// read combinationally. A push that finds the stack full wraps over the oldest
// entry. Checkpoint restore takes priority over push and pop.
module ras #(
  parameter  int RAS_DEPTH        = 8,
  parameter  int RAS_TARGET_WIDTH = 12,
  localparam int LOG_RAS_DEPTH    = $clog2(RAS_DEPTH)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        push_valid,
  input  logic [RAS_TARGET_WIDTH-1:0] push_target,
  input  logic                        pop_valid,
  output logic [RAS_TARGET_WIDTH-1:0] pop_target,
  output logic                        pop_empty,
  output logic [LOG_RAS_DEPTH-1:0]    ras_index,
  output logic [LOG_RAS_DEPTH:0]      ras_count,
  input  logic                        restore_valid,
  input  logic [LOG_RAS_DEPTH-1:0]    restore_index,
  input  logic [LOG_RAS_DEPTH:0]      restore_count
);

  localparam logic [LOG_RAS_DEPTH:0]   DEPTH_C   = RAS_DEPTH[LOG_RAS_DEPTH:0];
  localparam logic [LOG_RAS_DEPTH:0]   CNT_ZERO  = {(LOG_RAS_DEPTH+1){1'b0}};
  localparam logic [LOG_RAS_DEPTH:0]   CNT_ONE   = {{LOG_RAS_DEPTH{1'b0}}, 1'b1};
  localparam logic [LOG_RAS_DEPTH-1:0] PTR_ONE   = {{(LOG_RAS_DEPTH-1){1'b0}}, 1'b1};
  localparam logic [LOG_RAS_DEPTH-1:0] PTR_ZERO  = {LOG_RAS_DEPTH{1'b0}};
  localparam logic [RAS_TARGET_WIDTH-1:0] ENTRY_ZERO = {RAS_TARGET_WIDTH{1'b0}};

  logic [RAS_TARGET_WIDTH-1:0] entry_q [RAS_DEPTH];
  logic [LOG_RAS_DEPTH-1:0]    ptr_q, ptr_d;
  logic [LOG_RAS_DEPTH:0]      count_q, count_d;

  logic                        wr_en_s;
  logic [LOG_RAS_DEPTH-1:0]    wr_idx_s;
  logic [LOG_RAS_DEPTH-1:0]    top_idx_s;

  // The top of stack sits just below the next-free pointer.
  assign top_idx_s  = ptr_q - PTR_ONE;
  assign pop_target = entry_q[top_idx_s];
  assign pop_empty  = (count_q == CNT_ZERO);
  assign ras_index  = ptr_q;
  assign ras_count  = count_q;

  // Next-state pointer/count and the single entry write port.
  always_comb begin
    ptr_d    = ptr_q;
    count_d  = count_q;
    wr_en_s  = 1'b0;
    wr_idx_s = ptr_q;
    if (restore_valid) begin
      // Entries are left alone; an out-of-range checkpoint count is clamped.
      ptr_d = restore_index;
      if (restore_count > DEPTH_C) begin
        count_d = DEPTH_C;
      end else begin
        count_d = restore_count;
      end
    end else begin
      case ({push_valid, pop_valid})
        2'b10: begin
          wr_en_s  = 1'b1;
          wr_idx_s = ptr_q;
          ptr_d    = ptr_q + PTR_ONE;
          if (count_q == DEPTH_C) begin
            count_d = count_q;
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end
        2'b01: begin
          // The pointer moves even on an empty stack; the count floors at zero.
          ptr_d = ptr_q - PTR_ONE;
          if (count_q == CNT_ZERO) begin
            count_d = CNT_ZERO;
          end else begin
            count_d = count_q - CNT_ONE;
          end
        end
        2'b11: begin
          // Return followed by a call in one cycle: overwrite the top in place.
          wr_en_s  = 1'b1;
          wr_idx_s = top_idx_s;
          if (count_q == CNT_ZERO) begin
            count_d = CNT_ONE;
          end else begin
            count_d = count_q;
          end
        end
        default: begin
          ptr_d   = ptr_q;
          count_d = count_q;
        end
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_q   <= PTR_ZERO;
      count_q <= CNT_ZERO;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Stack storage, cleared on reset so the top reads zero afterwards.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        entry_q[i] <= ENTRY_ZERO;
      end
    end else if (wr_en_s) begin
      entry_q[wr_idx_s] <= push_target;
    end
  end

endmodule
